// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI responder.
// Optional build macro: SPI_SLAVE_MISO_TRISTATE_EN (see top).
package spi_pkg;

    localparam int SPI_DATA_WIDTH = 8;
    localparam logic [SPI_DATA_WIDTH-1:0] SPI_IDLE_FILL = 8'h00;
    localparam int SPI_CNT_W = $clog2(SPI_DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        ACTIVE
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one async input
// with single-cycle rise/fall strobes.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    // Shift the pin through the chain, keep a delayed copy for edges.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign q_o    = sync_q[SYNC_STAGES-1];
    assign rise_o = q_o & ~dly_q;
    assign fall_o = ~q_o & dly_q;

endmodule

// File: rtl/spi_slave_rx_tx.sv
// SPI mode-0 responder, MSB first, with one-word tx buffer.
// Define SPI_SLAVE_MISO_TRISTATE_EN to release miso outside a frame.
module spi_slave_rx_tx
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] IDLE_FILL =
        DATA_WIDTH'(SPI_IDLE_FILL)
) (
    input  logic                  in_clock,
    input  logic                  nreset,
    input  logic                  sclk,
    input  logic                  ncs,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int CntW = $clog2(DATA_WIDTH + 1);
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic ncs_s, ncs_rise, ncs_fall;
    logic mosi_s;
    logic [SYNC_STAGES-1:0] mosi_sync_q;

    spi_state_e state_q, state_d;
    logic [CntW-1:0] bit_cnt_q, bit_cnt_d, cnt_base;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d, fill;
    logic rx_valid_q, rx_valid_d;
    logic frame_err_q, frame_err_d;
    logic done_q, done_d;
    logic hold_q, hold_d;
    logic buf_full_q, buf_full_d;
    logic consume;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk_i  (in_clock),
        .rst_ni (nreset),
        .d_i    (sclk),
        .q_o    (sclk_s),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ncs_sync (
        .clk_i  (in_clock),
        .rst_ni (nreset),
        .d_i    (ncs),
        .q_o    (ncs_s),
        .rise_o (ncs_rise),
        .fall_o (ncs_fall)
    );

    // Data line needs only the level synchronizer.
    always_ff @(posedge in_clock or negedge nreset) begin
        if (!nreset) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        end
    end

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign fill   = buf_full_q ? buf_q : IDLE_FILL;

    // Next-state logic for the frame FSM, shifters and tx buffer.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        done_d      = 1'b0;
        hold_d      = hold_q;
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
        consume     = 1'b0;
        cnt_base    = done_q ? '0 : bit_cnt_q;

        unique case (state_q)
            WAIT_IDLE: begin
                if (ncs_s) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (ncs_fall) begin
                    state_d    = ACTIVE;
                    consume    = 1'b1;
                    tx_shift_d = fill;
                    bit_cnt_d  = '0;
                    hold_d     = 1'b0;
                end
            end
            ACTIVE: begin
                if (done_q) begin
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                    bit_cnt_d  = '0;
                end
                if (ncs_rise) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    hold_d    = 1'b0;
                    if (bit_cnt_q != '0 && !done_q) begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    if (done_q) begin
                        // The byte's closing fall may still be due;
                        // it must not shift the freshly loaded word.
                        consume    = 1'b1;
                        tx_shift_d = fill;
                        hold_d     = sclk_s;
                    end else if (sclk_fall) begin
                        if (hold_q) begin
                            hold_d = 1'b0;
                        end else begin
                            tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0],
                                          1'b0};
                        end
                    end
                    if (sclk_rise) begin
                        rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0],
                                      mosi_s};
                        bit_cnt_d  = cnt_base + CntW'(1);
                        done_d     = (cnt_base == LastBit);
                    end
                end
            end
            default: begin
                state_d = WAIT_IDLE;
            end
        endcase

        if (consume && buf_full_q) begin
            buf_full_d = 1'b0;
        end else if (tx_load && !buf_full_q) begin
            buf_d      = tx_data;
            buf_full_d = 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge in_clock or negedge nreset) begin
        if (!nreset) begin
            state_q     <= WAIT_IDLE;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            done_q      <= 1'b0;
            hold_q      <= 1'b0;
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            done_q      <= done_d;
            hold_q      <= hold_d;
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q == ACTIVE);
    assign tx_ready  = ~buf_full_q;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign miso = (state_q == ACTIVE && !ncs_s) ?
                  tx_shift_q[DATA_WIDTH-1] : 1'bz;
`else
    assign miso = (state_q == ACTIVE) ?
                  tx_shift_q[DATA_WIDTH-1] : 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Directed bench for spi_slave_rx_tx with a byte-level
// reference model of the rx stream and tx buffer.
module tb_spi_slave_rx_tx;

    localparam int TH = 50;
    localparam logic [7:0] FILL = 8'h00;

    logic       in_clock = 1'b0;
    logic       nreset   = 1'b0;
    logic       sclk     = 1'b0;
    logic       ncs      = 1'b1;
    logic       mosi     = 1'b0;
    logic       tx_load  = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       miso;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    spi_slave_rx_tx dut (
        .in_clock  (in_clock),
        .nreset    (nreset),
        .sclk      (sclk),
        .ncs       (ncs),
        .mosi      (mosi),
        .miso      (miso),
        .tx_data   (tx_data),
        .tx_load   (tx_load),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial forever #5 in_clock = ~in_clock;

    int vectors = 0;
    int errors  = 0;

    logic [7:0] rx_q[$];
    logic [7:0] held      = 8'h00;
    int         ferr_pend = 0;
    logic       m_full    = 1'b0;
    logic [7:0] m_buf     = 8'h00;
    bit         bus_idle  = 1'b0;

    logic [7:0] mi, mi1, mi2;
    logic       b;
    int         n;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    function automatic logic [7:0] m_take();
        if (m_full) begin
            m_full = 1'b0;
            return m_buf;
        end
        return FILL;
    endfunction

    task automatic m_reset();
        held      = 8'h00;
        rx_q.delete();
        m_full    = 1'b0;
        ferr_pend = 0;
    endtask

    // Every cycle: rx stream, frame errors and idle outputs.
    always @(negedge in_clock) begin
        if (nreset) begin
            if (rx_valid) begin
                if (rx_q.size() == 0) begin
                    chk("rx_valid_spurious", 32'd1, 32'd0);
                end else begin
                    held = rx_q.pop_front();
                    chk("rx_data_pulse", rx_data, held);
                end
            end else begin
                chk("rx_data_hold", rx_data, held);
            end
            if (frame_err) begin
                if (ferr_pend == 0)
                    chk("frame_err_spurious", 32'd1, 32'd0);
                else
                    ferr_pend--;
            end
            if (bus_idle) begin
                chk("busy_idle", busy, 0);
`ifndef SPI_SLAVE_MISO_TRISTATE_EN
                chk("miso_idle", miso, 0);
`endif
            end
        end
    end

    task automatic do_load(input logic [7:0] d);
        @(negedge in_clock);
        chk("tx_ready_pre", tx_ready, !m_full);
        if (!m_full) begin
            m_buf  = d;
            m_full = 1'b1;
        end
        tx_data = d;
        tx_load = 1'b1;
        @(negedge in_clock);
        tx_load = 1'b0;
    endtask

    task automatic start_frame();
        bus_idle = 1'b0;
        ncs = 1'b0;
        #(2 * TH);
        chk("busy_active", busy, 1);
    endtask

    task automatic end_frame();
        #(TH);
        ncs = 1'b1;
        #(3 * TH);
        bus_idle = 1'b1;
        chk("rx_drain", rx_q.size(), 0);
        chk("ferr_drain", ferr_pend, 0);
    endtask

    task automatic bit_x(input logic mo, output logic si);
        mosi = mo;
        #(TH);
        sclk = 1'b1;
        si   = miso;
        #(TH);
        sclk = 1'b0;
    endtask

    task automatic byte_x(input logic [7:0] mo,
                          output logic [7:0] so);
        logic [7:0] exp;
        logic       s;
        exp = m_take();
        rx_q.push_back(mo);
        for (int i = 7; i >= 0; i--) begin
            bit_x(mo[i], s);
            so[i] = s;
        end
        chk("miso_byte", so, exp);
    endtask

    initial begin
        @(negedge in_clock);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_miso", miso, 0);
        @(posedge in_clock);
        #2 nreset = 1'b1;
        repeat (10) @(negedge in_clock);
        bus_idle = 1'b1;

        // Single byte with a loaded tx word.
        do_load(8'hA5);
        start_frame();
        byte_x(8'h3C, mi);
        end_frame();
        chk("t1_miso", mi, 8'hA5);
        chk("t1_rx", rx_data, 8'h3C);
        chk("t1_ready", tx_ready, 1);

        // Two back-to-back bytes, second word loaded mid-frame.
        do_load(8'h11);
        start_frame();
        fork
            begin
                byte_x(8'h81, mi1);
                byte_x(8'h7E, mi2);
            end
            begin
                n = 0;
                while (!tx_ready && n < 60) begin
                    @(negedge in_clock);
                    n++;
                end
                chk("t2_ready_wait", n < 60, 1);
                do_load(8'h22);
            end
        join
        end_frame();
        chk("t2_miso0", mi1, 8'h11);
        chk("t2_miso1", mi2, 8'h22);
        chk("t2_rx", rx_data, 8'h7E);

        // Empty buffer sends the fill word.
        start_frame();
        byte_x(8'hFF, mi);
        end_frame();
        chk("t3_miso", mi, 8'h00);
        chk("t3_rx", rx_data, 8'hFF);

        // Partial byte aborted after five rises.
        start_frame();
        void'(m_take());
        for (int i = 0; i < 5; i++) bit_x(1'b0, b);
        ferr_pend++;
        end_frame();
        chk("t4_rx_kept", rx_data, 8'hFF);

        // Reset in the middle of a frame.
        start_frame();
        void'(m_take());
        for (int i = 0; i < 3; i++) bit_x(1'b1, b);
        @(posedge in_clock);
        #2 nreset = 1'b0;
        m_reset();
        @(negedge in_clock);
        chk("t5_rx_data", rx_data, 0);
        chk("t5_rx_valid", rx_valid, 0);
        chk("t5_frame_err", frame_err, 0);
        chk("t5_busy", busy, 0);
        chk("t5_tx_ready", tx_ready, 1);
        chk("t5_miso", miso, 0);
        @(posedge in_clock);
        #2 nreset = 1'b1;
        bus_idle = 1'b1;
        for (int i = 0; i < 5; i++) bit_x(1'b1, b);
        end_frame();
        start_frame();
        byte_x(8'h5A, mi);
        end_frame();
        chk("t5_rx", rx_data, 8'h5A);
        chk("t5_miso_fill", mi, 8'h00);

        // Load while full is dropped.
        do_load(8'h77);
        do_load(8'h99);
        chk("t6_ready_full", tx_ready, 0);
        start_frame();
        byte_x(8'h24, mi);
        end_frame();
        chk("t6_miso", mi, 8'h77);
        chk("t6_ready", tx_ready, 1);
        start_frame();
        byte_x(8'h42, mi);
        end_frame();
        chk("t6_no_99", mi, 8'h00);
        chk("t6_rx", rx_data, 8'h42);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
